// File: rtl/pal_dp_sched.sv
// Round-robin scheduler sharing one pipelined datapath among N_REQ requesters, with credit-limited
// issue, an in-order response ID FIFO and a flush/drain sequence. Optional PAL_SCHED_LOCK_EN adds
// per-requester grant locking.
module pal_dp_sched #(
  parameter int unsigned N_REQ     = 4,
  parameter int unsigned W_DATA    = 32,
  parameter int unsigned MAX_OUTST = 4,
  localparam int unsigned W_ID     = (N_REQ > 1) ? $clog2(N_REQ) : 1,
  localparam int unsigned W_CNT    = $clog2(MAX_OUTST) + 1
) (
  input  logic                      i_clk,
  input  logic                      resetn,
  input  logic [N_REQ-1:0]          i_req_valid,
  input  logic [N_REQ*W_DATA-1:0]   i_req_data,
`ifdef PAL_SCHED_LOCK_EN
  input  logic [N_REQ-1:0]          i_req_lock,
`endif
  output logic [N_REQ-1:0]          o_req_ready,
  output logic                      o_dp_valid,
  output logic [W_DATA-1:0]         o_dp_data,
  output logic [W_ID-1:0]           o_dp_id,
  input  logic                      i_dp_ready,
  input  logic                      i_rsp_valid,
  output logic [W_ID-1:0]           o_rsp_id,
  input  logic                      i_flush,
  output logic                      o_flush_done,
  output logic [W_CNT-1:0]          o_outst,
  output logic                      o_err
);

  localparam int unsigned W_PTR = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;

  typedef enum logic [0:0] {StRun, StDrain} state_e;

  state_e              state_q;
  logic                dp_valid_q;
  logic [W_DATA-1:0]   dp_data_q;
  logic [W_ID-1:0]     dp_id_q;
  logic [W_CNT-1:0]    outst_q;
  logic                flush_done_q;
  logic                err_q;
  logic [W_ID-1:0]     ptr_q;
  logic [W_ID-1:0]     fifo_q [MAX_OUTST];
  logic [W_PTR-1:0]    wr_q, rd_q;
`ifdef PAL_SCHED_LOCK_EN
  logic                lk_q;
`endif

  logic                fire, rsp_ok, can_accept, found, accept;
  logic [W_CNT:0]      pending;
  logic [W_ID-1:0]     base, grant_idx;
  logic [W_ID:0]       s;

  function automatic logic [W_ID-1:0] next_req(input logic [W_ID-1:0] i);
    logic [W_ID:0] n;
    n = {1'b0, i} + (W_ID+1)'(1);
    return (n == (W_ID+1)'(N_REQ)) ? '0 : n[W_ID-1:0];
  endfunction

  always_comb begin
    fire       = dp_valid_q & i_dp_ready;
    rsp_ok     = i_rsp_valid && (outst_q != '0);
    pending    = {1'b0, outst_q} + (W_CNT+1)'(dp_valid_q);
    can_accept = (state_q == StRun) && (pending < (W_CNT+1)'(MAX_OUTST)) && (!dp_valid_q || fire);
`ifdef PAL_SCHED_LOCK_EN
    // Once the holder releases its lock the scan resumes just past it.
    base = (lk_q && !(i_req_lock[ptr_q] && i_req_valid[ptr_q])) ? next_req(ptr_q) : ptr_q;
`else
    base = ptr_q;
`endif
    found     = 1'b0;
    grant_idx = '0;
    s         = '0;
    for (int i = 0; i < int'(N_REQ); i++) begin
      s = {1'b0, base} + (W_ID+1)'(i);
      if (s >= (W_ID+1)'(N_REQ)) s = s - (W_ID+1)'(N_REQ);
      if (!found && i_req_valid[s[W_ID-1:0]]) begin
        found     = 1'b1;
        grant_idx = s[W_ID-1:0];
      end
    end
    accept      = can_accept & found;
    o_req_ready = '0;
    if (accept) o_req_ready[grant_idx] = 1'b1;
  end

  always_ff @(posedge i_clk) begin
    if (!resetn) begin
      state_q      <= StRun;
      dp_valid_q   <= 1'b0;
      dp_data_q    <= '0;
      dp_id_q      <= '0;
      outst_q      <= '0;
      flush_done_q <= 1'b0;
      err_q        <= 1'b0;
      ptr_q        <= '0;
      wr_q         <= '0;
      rd_q         <= '0;
`ifdef PAL_SCHED_LOCK_EN
      lk_q         <= 1'b0;
`endif
    end else begin
      if (accept) begin
        dp_valid_q <= 1'b1;
        dp_data_q  <= i_req_data[grant_idx*W_DATA +: W_DATA];
        dp_id_q    <= grant_idx;
`ifdef PAL_SCHED_LOCK_EN
        ptr_q      <= i_req_lock[grant_idx] ? grant_idx : next_req(grant_idx);
        lk_q       <= i_req_lock[grant_idx];
`else
        ptr_q      <= next_req(grant_idx);
`endif
      end else if (fire) begin
        dp_valid_q <= 1'b0;
      end

      if (fire) begin
        fifo_q[wr_q] <= dp_id_q;
        wr_q         <= wr_q + W_PTR'(1);
      end
      if (rsp_ok) rd_q <= rd_q + W_PTR'(1);
      outst_q <= outst_q + W_CNT'(fire) - W_CNT'(rsp_ok);
      if (i_rsp_valid && !rsp_ok) err_q <= 1'b1;

      flush_done_q <= 1'b0;
      unique case (state_q)
        StRun: begin
          // A flush that finds nothing in flight completes without entering drain.
          if (i_flush) begin
            if (!dp_valid_q && outst_q == '0 && !accept) flush_done_q <= 1'b1;
            else                                         state_q      <= StDrain;
          end
        end
        StDrain: begin
          if (!dp_valid_q && outst_q == '0) begin
            state_q      <= StRun;
            flush_done_q <= 1'b1;
          end
        end
        default: state_q <= StRun;
      endcase
    end
  end

  assign o_dp_valid   = dp_valid_q;
  assign o_dp_data    = dp_data_q;
  assign o_dp_id      = dp_id_q;
  assign o_outst      = outst_q;
  assign o_flush_done = flush_done_q;
  assign o_err        = err_q;
  assign o_rsp_id     = (outst_q != '0) ? fifo_q[rd_q] : '0;

endmodule

// File: tb/tb_pal_dp_sched.sv
// Directed self-checking bench for pal_dp_sched; lock scenario runs when PAL_SCHED_LOCK_EN is set.
module tb_pal_dp_sched;
  localparam int N = 4;
  localparam int W = 32;

  logic           clk = 1'b0;
  logic           resetn;
  logic [N-1:0]   req_valid;
  logic [N*W-1:0] req_data;
  logic [N-1:0]   req_ready;
  logic           dp_valid;
  logic [W-1:0]   dp_data;
  logic [1:0]     dp_id;
  logic           dp_ready;
  logic           rsp_valid;
  logic [1:0]     rsp_id;
  logic           flush;
  logic           flush_done;
  logic [2:0]     outst;
  logic           err;
`ifdef PAL_SCHED_LOCK_EN
  logic [N-1:0]   req_lock;
`endif

  int nvec = 0;
  int nerr = 0;

  pal_dp_sched #(.N_REQ(N), .W_DATA(W), .MAX_OUTST(4)) dut (
    .i_clk        (clk),
    .resetn       (resetn),
    .i_req_valid  (req_valid),
    .i_req_data   (req_data),
`ifdef PAL_SCHED_LOCK_EN
    .i_req_lock   (req_lock),
`endif
    .o_req_ready  (req_ready),
    .o_dp_valid   (dp_valid),
    .o_dp_data    (dp_data),
    .o_dp_id      (dp_id),
    .i_dp_ready   (dp_ready),
    .i_rsp_valid  (rsp_valid),
    .o_rsp_id     (rsp_id),
    .i_flush      (flush),
    .o_flush_done (flush_done),
    .o_outst      (outst),
    .o_err        (err)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    req_valid = '0;
    dp_ready  = 1'b0;
    rsp_valid = 1'b0;
    flush     = 1'b0;
`ifdef PAL_SCHED_LOCK_EN
    req_lock  = '0;
`endif
    resetn = 1'b0;
    cyc();
    resetn = 1'b1;
  endtask

  task automatic drain();
    req_valid = '0;
    dp_ready  = 1'b1;
    flush     = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (!dp_valid && outst == 3'd0) break;
      rsp_valid = (outst != 3'd0);
      cyc();
    end
    rsp_valid = 1'b0;
    check_eq("drain_outst", 64'(outst), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    for (int k = 0; k < N; k++) req_data[k*W +: W] = 32'hD000 + k;
    do_reset();
    req_valid = '0;
    #1;
    check_eq("rst_dp_valid", 64'(dp_valid), 64'd0);
    check_eq("rst_dp_data", 64'(dp_data), 64'd0);
    check_eq("rst_dp_id", 64'(dp_id), 64'd0);
    check_eq("rst_outst", 64'(outst), 64'd0);
    check_eq("rst_flush_done", 64'(flush_done), 64'd0);
    check_eq("rst_err", 64'(err), 64'd0);

    // 1: full round robin, responses two cycles after each fire
    for (int t = 0; t < 10; t++) begin
      req_valid = 4'hF;
      dp_ready  = 1'b1;
      rsp_valid = (t >= 3);
      #1;
      check_eq("t1_ready", 64'(req_ready), 64'(1 << (t % 4)));
      if (t >= 1) begin
        check_eq("t1_dp_valid", 64'(dp_valid), 64'd1);
        check_eq("t1_dp_id", 64'(dp_id), 64'((t - 1) % 4));
        check_eq("t1_dp_data", 64'(dp_data), 64'(32'hD000 + (t - 1) % 4));
      end
      if (t >= 3) check_eq("t1_rsp_id", 64'(rsp_id), 64'((t - 3) % 4));
      cyc();
    end
    drain();

    // 2: credit limit
    do_reset();
    for (int t = 0; t < 7; t++) begin
      req_valid = 4'hF;
      dp_ready  = 1'b1;
      #1;
      check_eq("t2_ready", 64'(req_ready), (t < 4) ? 64'(1 << t) : 64'd0);
      cyc();
    end
    check_eq("t2_outst", 64'(outst), 64'd4);
    check_eq("t2_dp_valid", 64'(dp_valid), 64'd0);
    rsp_valid = 1'b1;
    #1;
    check_eq("t2_rsp_id", 64'(rsp_id), 64'd0);
    check_eq("t2_ready_rsp", 64'(req_ready), 64'd0);
    cyc();
    rsp_valid = 1'b0;
    #1;
    check_eq("t2_outst_after", 64'(outst), 64'd3);
    check_eq("t2_ready_credit", 64'(req_ready), 64'b0001);
    drain();

    // 3: stalled slot holds; dropping valid mid-stall has no effect
    do_reset();
    req_valid = 4'b0100;
    dp_ready  = 1'b0;
    #1;
    check_eq("t3_ready0", 64'(req_ready), 64'b0100);
    cyc();
    for (int t = 1; t <= 5; t++) begin
      req_valid = (t == 3) ? 4'b0000 : 4'b0100;
      #1;
      check_eq("t3_dp_valid", 64'(dp_valid), 64'd1);
      check_eq("t3_dp_id", 64'(dp_id), 64'd2);
      check_eq("t3_dp_data", 64'(dp_data), 64'h0000D002);
      check_eq("t3_ready", 64'(req_ready), 64'd0);
      cyc();
    end
    drain();

    // 4: flush with three in flight and a full slot
    do_reset();
    req_valid = 4'hF;
    dp_ready  = 1'b1;
    for (int t = 0; t < 4; t++) cyc();
    check_eq("t4_outst3", 64'(outst), 64'd3);
    check_eq("t4_dp_id", 64'(dp_id), 64'd3);
    dp_ready = 1'b0;
    flush    = 1'b1;
    #1;
    check_eq("t4_ready_fl", 64'(req_ready), 64'd0);
    cyc();
    flush    = 1'b0;
    dp_ready = 1'b1;
    #1;
    check_eq("t4_ready_drain", 64'(req_ready), 64'd0);
    cyc();
    for (int k = 0; k < 4; k++) begin
      rsp_valid = 1'b1;
      #1;
      check_eq("t4_rsp_id", 64'(rsp_id), 64'(k));
      check_eq("t4_ready_rsp", 64'(req_ready), 64'd0);
      check_eq("t4_done_early", 64'(flush_done), 64'd0);
      cyc();
    end
    rsp_valid = 1'b0;
    #1;
    check_eq("t4_done_pre", 64'(flush_done), 64'd0);
    check_eq("t4_ready_idle", 64'(req_ready), 64'd0);
    cyc();
    check_eq("t4_done", 64'(flush_done), 64'd1);
    check_eq("t4_ready_resume", 64'(req_ready), 64'b0001);
    cyc();
    check_eq("t4_done_once", 64'(flush_done), 64'd0);
    drain();

    // flush while idle completes on the following cycle
    do_reset();
    flush = 1'b1;
    cyc();
    flush = 1'b0;
    #1;
    check_eq("idle_done", 64'(flush_done), 64'd1);
    cyc();
    check_eq("idle_done_once", 64'(flush_done), 64'd0);

    // 5: spurious response after reset drops in-flight work
    do_reset();
    req_valid = 4'b0001;
    dp_ready  = 1'b1;
    cyc();
    req_valid = '0;
    cyc();
    req_valid = 4'b0010;
    dp_ready  = 1'b0;
    cyc();
    req_valid = '0;
    #1;
    check_eq("t5_outst1", 64'(outst), 64'd1);
    check_eq("t5_dp_id", 64'(dp_id), 64'd1);
    resetn = 1'b0;
    cyc();
    resetn = 1'b1;
    check_eq("t5_rst_dp_valid", 64'(dp_valid), 64'd0);
    check_eq("t5_rst_dp_id", 64'(dp_id), 64'd0);
    check_eq("t5_rst_dp_data", 64'(dp_data), 64'd0);
    check_eq("t5_rst_outst", 64'(outst), 64'd0);
    rsp_valid = 1'b1;
    #1;
    check_eq("t5_rsp_id", 64'(rsp_id), 64'd0);
    cyc();
    rsp_valid = 1'b0;
    check_eq("t5_err", 64'(err), 64'd1);
    check_eq("t5_outst", 64'(outst), 64'd0);
    cyc();
    check_eq("t5_err_sticky", 64'(err), 64'd1);
    do_reset();
    #1;
    check_eq("t5_err_clr", 64'(err), 64'd0);

`ifdef PAL_SCHED_LOCK_EN
    // 6: lock holds requester 1, release hands over to 3
    do_reset();
    for (int t = 0; t < 5; t++) begin
      req_valid = 4'b1010;
      req_lock  = (t < 4) ? 4'b0010 : 4'b0000;
      dp_ready  = 1'b1;
      rsp_valid = (t >= 3);
      #1;
      check_eq("t6_ready", 64'(req_ready), (t < 4) ? 64'b0010 : 64'b1000);
      if (t >= 1) check_eq("t6_dp_id", 64'(dp_id), 64'd1);
      cyc();
    end
    req_lock = '0;
    drain();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule

// File: doc/pal_dp_sched.md
Name: pal_dp_sched

Overview:
Round-robin scheduler that shares one pipelined W_DATA-wide datapath among N_REQ requesters. Each request is accepted into a single output slot and issued to the datapath with a valid/ready handshake, tagged with its requester ID. The number of in-flight operations is credit-limited. Responses come back in order, and the scheduler returns the matching requester ID from an internal ID FIFO. A flush/drain sequence quiesces the datapath before it is reconfigured.

Parameters:
N_REQ, 4, number of requesters (2..16)
W_DATA, 32, request/datapath data width
MAX_OUTST, 4, maximum issued-but-unanswered operations; also the ID FIFO depth (power of 2)
W_ID, clog2(N_REQ) (localparam), requester ID width

Ports:
i_clk  in  1  clock
resetn  in  1  synchronous active-low reset
i_req_valid  in  N_REQ  per-requester request valid
i_req_data  in  N_REQ*W_DATA  per-requester data; requester k occupies bits [k*W_DATA +: W_DATA]
o_req_ready  out  N_REQ  one-hot accept strobe (combinational)
o_dp_valid  out  1  slot holds an operation for the datapath
o_dp_data  out  W_DATA  slot data
o_dp_id  out  W_ID  slot requester ID
i_dp_ready  in  1  datapath accepts the slot
i_rsp_valid  in  1  datapath result returned, in issue order
o_rsp_id  out  W_ID  requester ID of the current response (combinational, FIFO head)
i_flush  in  1  single-cycle drain request
o_flush_done  out  1  one-cycle pulse when the drain completes
o_outst  out  clog2(MAX_OUTST)+1  in-flight count
o_err  out  1  sticky flag: response received with no operation in flight

Behaviour:
- Reset (resetn=0 at a clock edge): o_dp_valid=0, o_dp_data=0, o_dp_id=0, o_outst=0, o_flush_done=0, o_err=0, RR pointer=0, ID FIFO empty, state=RUN. A reset mid-operation drops the slot and all in-flight IDs. Responses arriving after reset are treated as spurious and set o_err.
- fire = o_dp_valid & i_dp_ready.
- pending = o_outst + o_dp_valid (registered values only).
- can_accept = (state==RUN) & (pending < MAX_OUTST) & (!o_dp_valid | fire).
- Arbitration: if can_accept and any i_req_valid is set, grant the first set bit at or after the RR pointer, scanning upward with wrap at N_REQ. Assert o_req_ready[g]=1 in that cycle; all other bits are 0. On the next edge, the slot loads data[g] with ID g, o_dp_valid=1, and pointer = (g+1) mod N_REQ.
- Throughput: back-to-back issue at 1 per cycle while i_dp_ready=1 and credit is available. Latency is 1 cycle from accept to o_dp_valid.
- Slot holding: while o_dp_valid=1 and i_dp_ready=0, o_dp_data and o_dp_id stay stable. If fire occurs with no new accept, o_dp_valid=0 next cycle.
- Issue side: on fire, push o_dp_id into the ID FIFO and increment o_outst.
- Response side: on i_rsp_valid with o_outst>0, o_rsp_id=head, pop the FIFO and decrement o_outst. Fire and response in the same cycle leave o_outst unchanged; the FIFO pushes and pops simultaneously.
- Spurious response: i_rsp_valid with o_outst==0 leaves the FIFO and count untouched, sets o_err=1, and o_rsp_id=0. o_err clears only on reset.
- Credit boundary: when pending==MAX_OUTST, no accept is made, even if i_rsp_valid is set in that cycle (credit is returned one cycle later).
- Pointer hold: if no requester is valid, the pointer does not move.
- Mid-handshake request drops: a requester dropping i_req_valid while the slot is stalled has no effect; it was either already accepted or never granted.
- State RUN -> DRAIN on i_flush=1. In DRAIN, no accepts are made; the existing slot still issues normally.
- State DRAIN -> RUN when o_dp_valid==0 and o_outst==0, evaluated on registered values. o_flush_done=1 for exactly that one cycle.
- i_flush while already in DRAIN is ignored. If i_flush arrives with the scheduler already idle, o_flush_done pulses on the next cycle.

Optional Feature:
PAL_SCHED_LOCK_EN
- Defined: adds input i_req_lock[N_REQ].
  - If the granted requester has its lock bit set at grant, the pointer is set to g instead of g+1.
  - While lock[g] and valid[g] remain high, g wins every arbitration.
  - Releasing the lock returns to RR from g+1.
  - DRAIN overrides the lock.
- Undefined: the port is absent and arbitration is pure round-robin.

Test Plan:
1. After reset, hold i_dp_ready=1 and drive requesters 0-3 continuously, with responses returning 2 cycles after each fire -> o_dp_id sequence 0,1,2,3,0,...; one issue per cycle; o_rsp_id follows the same sequence.
2. Hold i_dp_ready=1 with no responses for 6 requests -> exactly 4 fire; o_outst=4; o_req_ready stays 0. One i_rsp_valid -> the next accept occurs one cycle later.
3. Hold i_dp_ready=0 for 5 cycles with requester 2 valid -> o_dp_valid=1 and o_dp_data/o_dp_id=2 stay stable; no second accept occurs.
4. With o_outst=3 and slot full, pulse i_flush -> no accepts; after the slot fires and 4 responses return, o_flush_done pulses once, then arbitration resumes.
5. Assert i_rsp_valid with o_outst=0 -> o_err=1 persistent, o_outst stays 0. Assert resetn=0 for one cycle -> all outputs return to 0.
6. (LOCK_EN) Requesters 1 and 3 valid, lock[1]=1 for 4 grants -> IDs 1,1,1,1; drop lock -> next grant goes to 3.
